// File: rtl/demux_reg.sv
// Registered 1-to-4 valid/ready demux with one holding slot per port; out-of-range selects are dropped and counted.
// Output is valid one cycle after acceptance; a stalled port only blocks transfers aimed at it.
module demux_reg #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_sel,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic               drop_err,
  output logic [7:0]         drop_count
);

  logic [3:0]            slot_full;
  logic [3:0][WIDTH-1:0] slot_data;
  logic [3:0]            fill;
  logic [3:0]            drain;
  logic                  drop;
  logic [1:0]            port;

  assign port = in_sel[1:0];

  // A full slot can still accept when its consumer drains it at the same edge.
  always_comb begin
    in_ready = 1'b1;
    if (!in_sel[2]) begin
      in_ready = !slot_full[port] || out_ready[port];
    end
  end

  always_comb begin
    fill = 4'b0000;
    if (in_valid && in_ready && !in_sel[2]) begin
      fill[port] = 1'b1;
    end
  end

  assign drain = slot_full & out_ready;
  assign drop  = in_valid && in_sel[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_full <= 4'b0000;
      slot_data <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (fill[i]) begin
          slot_full[i] <= 1'b1;
          slot_data[i] <= in_data;
        end else if (drain[i]) begin
          slot_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_err   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      drop_err <= 1'b1;
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  assign out_valid = slot_full;
  assign out_data  = slot_data;

endmodule

// File: tb/tb_demux_reg.sv
// Bench for demux_reg: vector table plus per-port scoreboard queues, and sequences for
// out-of-range drop saturation and asynchronous reset with held transfers.
module tb_demux_reg;

  localparam int W = 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [2:0]     in_sel;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [4*W-1:0] out_data;
  logic           drop_err;
  logic [7:0]     drop_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q [4][$];
  int           exp_cnt = 0;
  bit           exp_err = 1'b0;

  typedef struct {
    bit         v;
    logic [2:0] sel;
    logic       d;
    logic [3:0] rdy;
    bit         er;
    logic [3:0] eov;
  } vec_t;

  vec_t tbl [18];

  demux_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_err  (drop_err),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, check outputs at the negedge against the model, then advance the model.
  task automatic cycle(input bit v, input logic [2:0] sel, input logic d, input logic [3:0] rdy,
                       output bit obs_ir, output logic [3:0] obs_ov);
    logic [3:0] ev;
    bit         er;
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = rdy;
    @(negedge clk);
    obs_ir = in_ready;
    obs_ov = out_valid;
    for (int i = 0; i < 4; i++) ev[i] = (q[i].size() != 0);
    chk("out_valid", {28'd0, out_valid}, {28'd0, ev});
    for (int i = 0; i < 4; i++)
      if (ev[i]) chk($sformatf("out_data[%0d]", i), {31'd0, out_data[i*W +: W]}, {31'd0, q[i][0]});
    er = sel[2] || !ev[sel[1:0]] || rdy[sel[1:0]];
    chk("in_ready", {31'd0, in_ready}, {31'd0, er});
    chk("drop_count", {24'd0, drop_count}, exp_cnt);
    chk("drop_err", {31'd0, drop_err}, {31'd0, exp_err});
    for (int i = 0; i < 4; i++)
      if (ev[i] && rdy[i]) void'(q[i].pop_front());
    if (v && er) begin
      if (sel[2]) begin
        exp_err = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
      end else begin
        q[sel[1:0]].push_back(d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit         ir;
    logic [3:0] ov;

    tbl[0]  = '{1'b1, 3'd1, 1'b1, 4'hF, 1'b1, 4'b0000};
    tbl[1]  = '{1'b1, 3'd0, 1'b0, 4'hF, 1'b1, 4'b0010};
    tbl[2]  = '{1'b1, 3'd2, 1'b1, 4'hF, 1'b1, 4'b0001};
    tbl[3]  = '{1'b1, 3'd3, 1'b0, 4'hF, 1'b1, 4'b0100};
    tbl[4]  = '{1'b0, 3'd0, 1'b0, 4'hF, 1'b1, 4'b1000};
    tbl[5]  = '{1'b0, 3'd2, 1'b1, 4'hF, 1'b1, 4'b0000};
    tbl[6]  = '{1'b1, 3'd2, 1'b1, 4'hB, 1'b1, 4'b0000};
    tbl[7]  = '{1'b1, 3'd2, 1'b0, 4'hB, 1'b0, 4'b0100};
    tbl[8]  = '{1'b1, 3'd2, 1'b0, 4'hB, 1'b0, 4'b0100};
    tbl[9]  = '{1'b1, 3'd0, 1'b1, 4'hB, 1'b1, 4'b0100};
    tbl[10] = '{1'b1, 3'd3, 1'b1, 4'hB, 1'b1, 4'b0101};
    tbl[11] = '{1'b1, 3'd2, 1'b0, 4'hF, 1'b1, 4'b1100};
    tbl[12] = '{1'b0, 3'd0, 1'b1, 4'hB, 1'b1, 4'b0100};
    tbl[13] = '{1'b0, 3'd0, 1'b0, 4'hF, 1'b1, 4'b0100};
    tbl[14] = '{1'b0, 3'd0, 1'b0, 4'hF, 1'b1, 4'b0000};
    tbl[15] = '{1'b1, 3'd4, 1'b1, 4'hF, 1'b1, 4'b0000};
    tbl[16] = '{1'b1, 3'd7, 1'b0, 4'hF, 1'b1, 4'b0000};
    tbl[17] = '{1'b0, 3'd0, 1'b0, 4'hF, 1'b1, 4'b0000};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sel    = 3'd0;
    in_data   = '0;
    out_ready = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", {28'd0, out_valid}, 32'd0);
    chk("reset drop_count", {24'd0, drop_count}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int n = 0; n < 18; n++) begin
      cycle(tbl[n].v, tbl[n].sel, tbl[n].d, tbl[n].rdy, ir, ov);
      chk($sformatf("tbl%0d in_ready", n), {31'd0, ir}, {31'd0, tbl[n].er});
      chk($sformatf("tbl%0d out_valid", n), {28'd0, ov}, {28'd0, tbl[n].eov});
    end
    chk("drop_count after two drops", {24'd0, drop_count}, 32'd2);
    chk("drop_err after drops", {31'd0, drop_err}, 32'd1);

    for (int n = 0; n < 300; n++) cycle(1'b1, 3'd5, n[0], 4'hF, ir, ov);
    cycle(1'b0, 3'd0, 1'b0, 4'hF, ir, ov);
    chk("drop_count saturated", {24'd0, drop_count}, 32'd255);

    cycle(1'b1, 3'd0, 1'b1, 4'h0, ir, ov);
    cycle(1'b1, 3'd1, 1'b1, 4'h0, ir, ov);
    cycle(1'b0, 3'd0, 1'b0, 4'h0, ir, ov);
    chk("two slots full", {28'd0, out_valid}, 32'h3);
    reset = 1'b1;
    #1;
    chk("async reset out_valid", {28'd0, out_valid}, 32'd0);
    chk("async reset out_data", {28'd0, out_data}, 32'd0);
    chk("async reset drop_count", {24'd0, drop_count}, 32'd0);
    chk("async reset drop_err", {31'd0, drop_err}, 32'd0);
    chk("async reset in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) q[i].delete();
    exp_cnt = 0;
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      cycle(1'b0, 3'd1, 1'b0, 4'hF, ir, ov);
      chk("no output after reset", {28'd0, ov}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_reg.md
# demux_reg

Registered 1-to-4 demultiplexer with valid/ready handshaking. It sends a single producer stream to one of four consumer ports, chosen per transfer by a 3-bit select, so it is the distribution counterpart of the datapath's 4:1 select mux. Each output has a one-entry holding register, so a stalled consumer blocks only transfers aimed at it. Out-of-range selects (4–7) are consumed and dropped, and each drop is counted.

## Interface
- WIDTH, default 1: data width of each transfer.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a transfer this cycle.
- in_ready  output  1  block accepts the transfer this cycle.
- in_data  input  WIDTH  transfer payload.
- in_sel  input  3  destination port; 0–3 are valid, 4–7 mean drop.
- out_valid  output  4  bit i: port i holds a transfer.
- out_ready  input  4  bit i: consumer i takes the transfer this cycle.
- out_data  output  4*WIDTH  port i payload in bits [i*WIDTH +: WIDTH].
- drop_err  output  1  sticky; set on the first dropped transfer.
- drop_count  output  8  number of dropped transfers, saturating at 255.

## Operation
- Per-port state:
  - slot_full[i], which drives out_valid[i];
  - slot_data[i], which drives the port i payload.
- Transfer terms:
  - Input transfer: in_valid && in_ready.
  - Output transfer on port i: out_valid[i] && out_ready[i].
- in_ready is combinational from in_sel, slot_full and out_ready. It does not depend on in_valid.
  - in_sel ≥ 4: in_ready = 1.
  - in_sel = k, where k < 4: in_ready = !slot_full[k] || out_ready[k].
- Input transfer with in_sel = k < 4:
  - slot_data[k] ← in_data.
  - slot_full[k] ← 1.
- Input transfer with in_sel ≥ 4:
  - No slot is touched.
  - drop_err ← 1.
  - drop_count increments if below 255, otherwise holds at 255.
- Output transfer on port i with no refill of slot i in the same cycle: slot_full[i] ← 0. slot_data[i] holds its value.
- Output transfer on port k and input transfer to k in the same cycle (refill): slot_full[k] stays 1 and slot_data[k] takes the new in_data. No bubble.
- Ports are independent. Any number of ports may drain in one cycle. At most one port fills per cycle.
- While out_valid[i] = 1 and out_ready[i] = 0, out_data for port i must stay stable.
- drop_err and drop_count clear only on reset.
- Reset values (asynchronous, taking effect immediately):
  - out_valid = 4'b0000.
  - out_data = 0.
  - drop_err = 0.
  - drop_count = 8'd0.
  - in_ready is combinational, so it reads 1 for any in_sel.
- Reset asserted mid-operation discards every held transfer. Nothing is emitted after reset is released.

## Timing
- Latency: an input transfer at edge N sets out_valid[k] immediately after edge N, so the payload is visible one cycle after acceptance.
- Throughput: one transfer per cycle in steady state, including back-to-back transfers to the same port whose consumer holds out_ready high.
- Full port k with out_ready[k] = 0: in_ready = 0 whenever in_sel = k. The producer must hold in_valid, in_data and in_sel until the transfer occurs.
- Full port k with out_ready[k] = 1: the drain and the refill happen at the same edge.
- A drop completes in one cycle. drop_count updates at the accepting edge.
- in_sel changing while in_valid = 0 has no effect on state.
- No combinational path exists from in_valid to in_ready, or from out_ready to out_valid.

## Test plan
- Reset check.
  - Stimulus: assert reset mid-cycle with two slots full.
  - Required: out_valid = 0, drop_count = 0 and drop_err = 0 immediately, before the next edge. No output after release.
- Basic routing.
  - Stimulus: WIDTH = 1; send data = 1, 0, 1, 0 to sel 1, 0, 2, 3 with out_ready = 4'hF.
  - Required: each port shows out_valid for exactly one cycle, one cycle after its accept, with matching data.
- Backpressure.
  - Stimulus: out_ready[2] = 0; send to sel 2 twice.
  - Required: the second attempt sees in_ready = 0 and port 2 holds the first data.
  - Stimulus continued: raise out_ready[2].
  - Required: the first transfer drains and the second loads at the same edge; out_valid[2] stays high.
- Port independence.
  - Stimulus: port 2 blocked and full; send to sel 0 and sel 3.
  - Required: both are accepted immediately.
- Out-of-range drop.
  - Stimulus: send with sel = 4, then sel = 7.
  - Required: in_ready = 1, out_valid is unchanged, drop_err = 1, drop_count = 2.
- Saturation.
  - Stimulus: 300 transfers with sel = 5.
  - Required: drop_count = 255.
